// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, request field
// constants and the captured-request record.
package lsu_pkg;

    localparam int TAG_W = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BYTE0 = 2'd1;
    localparam logic [1:0] ST_BYTE1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic RQ_CMD_LOAD   = 1'b0;
    localparam logic RQ_CMD_STORE  = 1'b1;
    localparam logic RQ_WIDTH_BYTE = 1'b0;
    localparam logic RQ_WIDTH_WORD = 1'b1;

    typedef struct packed {
        logic             cmd;
        logic             width;
        logic [TAG_W-1:0] tag;
        logic [15:0]      adr;
        logic [15:0]      wdata;
    } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: splits 8/16-bit accesses into byte cycles on an 8-bit bus
// and returns load results with the requester's tag as a one-cycle strobe.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             a_rst,
    input  logic             rq_start,
    input  logic             rq_cmd,
    input  logic             rq_width,
    input  logic [TAG_W-1:0] rq_tag,
    input  logic [15:0]      rq_adr,
    input  logic [15:0]      rq_wdata,
    output logic             lsu_wait,
    output logic [15:0]      data_out,
    output logic [TAG_W:0]   data_tag,
    output logic             data_wb,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_adr,
    output logic [7:0]       mem_wdata,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata
);

    logic [1:0]  state_reg, state_next;
    lsu_req_t    req_reg, req_next;
    logic [15:0] data_reg, data_next;
    logic        accept;

    // RESP also accepts so a result strobe and the next request's first bus
    // cycle can run back to back.
    assign accept = rq_start && (state_reg == ST_IDLE || state_reg == ST_RESP);

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_BYTE0: begin
                if (mem_ack) begin
                    if (req_reg.width == RQ_WIDTH_WORD) begin
                        state_next = ST_BYTE1;
                        if (req_reg.cmd == RQ_CMD_LOAD)
                            data_next[7:0] = mem_rdata;
                    end else if (req_reg.cmd == RQ_CMD_LOAD) begin
                        state_next = ST_RESP;
                        data_next  = {8'h00, mem_rdata};
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BYTE1: begin
                if (mem_ack) begin
                    if (req_reg.cmd == RQ_CMD_LOAD) begin
                        state_next      = ST_RESP;
                        data_next[15:8] = mem_rdata;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                if (accept) begin
                    state_next     = ST_BYTE0;
                    req_next.cmd   = rq_cmd;
                    req_next.width = rq_width;
                    req_next.tag   = rq_tag;
                    req_next.adr   = rq_adr;
                    req_next.wdata = rq_wdata;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_reg <= ST_IDLE;
            req_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            data_reg  <= data_next;
        end
    end

    // Bus outputs decode straight from the state register, so an asynchronous
    // reset drops mem_req without waiting for a clock edge.
    always_comb begin
        lsu_wait  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = 16'h0000;
        mem_wdata = 8'h00;
        case (state_reg)
            ST_BYTE0: begin
                lsu_wait  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = req_reg.cmd;
                mem_adr   = req_reg.adr;
                mem_wdata = req_reg.wdata[7:0];
            end
            ST_BYTE1: begin
                lsu_wait  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = req_reg.cmd;
                mem_adr   = req_reg.adr + 16'd1;
                mem_wdata = req_reg.wdata[15:8];
            end
            default: ;
        endcase
    end

    assign data_wb  = (state_reg == ST_RESP);
    assign data_out = data_reg;
    assign data_tag = {1'b0, req_reg.tag};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors per scenario,
// bus acknowledged by the bench cycle by cycle.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        rq_start, rq_cmd, rq_width;
    logic [0:0]  rq_tag;
    logic [15:0] rq_adr, rq_wdata;
    logic        lsu_wait, data_wb, mem_req, mem_we, mem_ack;
    logic [15:0] data_out, mem_adr;
    logic [1:0]  data_tag;
    logic [7:0]  mem_wdata, mem_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    load_store_unit dut (
        .clk(clk), .a_rst(a_rst),
        .rq_start(rq_start), .rq_cmd(rq_cmd), .rq_width(rq_width), .rq_tag(rq_tag),
        .rq_adr(rq_adr), .rq_wdata(rq_wdata),
        .lsu_wait(lsu_wait), .data_out(data_out), .data_tag(data_tag), .data_wb(data_wb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic cmd, input logic width, input logic tag,
                             input logic [15:0] adr, input logic [15:0] wdata);
        rq_start = 1'b1; rq_cmd = cmd; rq_width = width;
        rq_tag = tag; rq_adr = adr; rq_wdata = wdata;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; rq_start = 0; rq_cmd = 0; rq_width = 0; rq_tag = 0;
        rq_adr = 0; rq_wdata = 0; mem_ack = 0; mem_rdata = 0;
        step();
        n_compared++; if ({lsu_wait, data_wb, mem_req, mem_we} !== 4'b0000) begin n_mismatched++; $display("FAIL reset_flags: got %b expected 0000", {lsu_wait, data_wb, mem_req, mem_we}); end
        n_compared++; if ({mem_adr, mem_wdata} !== 24'h0) begin n_mismatched++; $display("FAIL reset_bus: got %h expected 000000", {mem_adr, mem_wdata}); end
        n_compared++; if ({data_out, data_tag} !== 18'h0) begin n_mismatched++; $display("FAIL reset_data: got %h expected 00000", {data_out, data_tag}); end
        $display("reset: lsu_wait=%b mem_req=%b data_out=%h", lsu_wait, mem_req, data_out);
        a_rst = 1'b0;
    endtask

    // Request is presented in the cycle reset is released: first edge must accept it.
    task automatic test_byte_load();
        drive_req(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000);
        n_compared++; if (lsu_wait !== 1'b0) begin n_mismatched++; $display("FAIL bl_wait_T: got %b expected 0", lsu_wait); end
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'hA5;
        n_compared++; if ({mem_req, mem_we, lsu_wait} !== 3'b101) begin n_mismatched++; $display("FAIL bl_ctrl_T1: got %b expected 101", {mem_req, mem_we, lsu_wait}); end
        n_compared++; if (mem_adr !== 16'h1234) begin n_mismatched++; $display("FAIL bl_adr_T1: got %h expected 1234", mem_adr); end
        step();
        mem_ack = 0;
        n_compared++; if ({data_wb, mem_req, lsu_wait} !== 3'b100) begin n_mismatched++; $display("FAIL bl_wb_T2: got %b expected 100", {data_wb, mem_req, lsu_wait}); end
        n_compared++; if (data_out !== 16'h00A5) begin n_mismatched++; $display("FAIL bl_data: got %h expected 00a5", data_out); end
        n_compared++; if (data_tag !== 2'b01) begin n_mismatched++; $display("FAIL bl_tag: got %b expected 01", data_tag); end
        $display("byte load: adr=1234 data_out=%h tag=%b", data_out, data_tag);
        step();
        n_compared++; if ({data_wb, lsu_wait} !== 2'b00) begin n_mismatched++; $display("FAIL bl_idle_T3: got %b expected 00", {data_wb, lsu_wait}); end
    endtask

    task automatic test_word_load_wrap();
        drive_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'h34;
        n_compared++; if (mem_adr !== 16'hFFFF) begin n_mismatched++; $display("FAIL wl_adr0: got %h expected ffff", mem_adr); end
        step();
        mem_rdata = 8'h12;
        n_compared++; if ({mem_req, data_wb} !== 2'b10) begin n_mismatched++; $display("FAIL wl_ctrl1: got %b expected 10", {mem_req, data_wb}); end
        n_compared++; if (mem_adr !== 16'h0000) begin n_mismatched++; $display("FAIL wl_adr1: got %h expected 0000", mem_adr); end
        step();
        mem_ack = 0;
        n_compared++; if (data_wb !== 1'b1) begin n_mismatched++; $display("FAIL wl_wb: got %b expected 1", data_wb); end
        n_compared++; if ({data_out, data_tag} !== {16'h1234, 2'b00}) begin n_mismatched++; $display("FAIL wl_data: got %h/%b expected 1234/00", data_out, data_tag); end
        $display("word load: adr=ffff data_out=%h", data_out);
        step();
    endtask

    task automatic test_word_store_wait();
        int wait_cycles = 0;
        int wb_seen = 0;
        drive_req(1'b1, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
        step();
        rq_start = 0;
        for (int i = 1; i <= 6; i++) begin
            mem_ack = (i == 3 || i == 6);
            if (lsu_wait) wait_cycles++;
            if (data_wb) wb_seen++;
            n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("FAIL ws_we_c%0d: got %b expected 1", i, mem_we); end
            n_compared++; if ({mem_adr, mem_wdata} !== ((i <= 3) ? 24'h0200EF : 24'h0201BE)) begin n_mismatched++; $display("FAIL ws_bus_c%0d: got %h expected %h", i, {mem_adr, mem_wdata}, (i <= 3) ? 24'h0200EF : 24'h0201BE); end
            step();
        end
        mem_ack = 0;
        if (lsu_wait) wait_cycles++;
        if (data_wb) wb_seen++;
        n_compared++; if (wait_cycles !== 6) begin n_mismatched++; $display("FAIL ws_wait_len: got %0d expected 6", wait_cycles); end
        n_compared++; if (wb_seen !== 0) begin n_mismatched++; $display("FAIL ws_no_wb: got %0d expected 0", wb_seen); end
        n_compared++; if (mem_req !== 1'b0) begin n_mismatched++; $display("FAIL ws_done: got %b expected 0", mem_req); end
        $display("word store: adr=0200 data=beef wait_cycles=%0d", wait_cycles);
    endtask

    task automatic test_byte_store();
        drive_req(1'b1, 1'b0, 1'b0, 16'h0300, 16'h1122);
        step();
        rq_start = 0; mem_ack = 1;
        n_compared++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 16'h0300, 8'h22}) begin n_mismatched++; $display("FAIL bs_bus: got %h expected 1030022", {mem_we, mem_adr, mem_wdata}); end
        step();
        mem_ack = 0;
        n_compared++; if ({lsu_wait, mem_req, data_wb} !== 3'b000) begin n_mismatched++; $display("FAIL bs_done: got %b expected 000", {lsu_wait, mem_req, data_wb}); end
        $display("byte store: adr=0300 byte=22");
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000);
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'h5A;
        step();
        mem_ack = 0; mem_rdata = 8'h00;
        drive_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'hFFFF);
        n_compared++; if ({data_wb, lsu_wait} !== 2'b10) begin n_mismatched++; $display("FAIL b2b_wb1: got %b expected 10", {data_wb, lsu_wait}); end
        n_compared++; if ({data_out, data_tag} !== {16'h005A, 2'b01}) begin n_mismatched++; $display("FAIL b2b_data1: got %h/%b expected 005a/01", data_out, data_tag); end
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'h77;
        n_compared++; if ({mem_req, data_wb, lsu_wait} !== 3'b101) begin n_mismatched++; $display("FAIL b2b_byte0: got %b expected 101", {mem_req, data_wb, lsu_wait}); end
        n_compared++; if (mem_adr !== 16'h0020) begin n_mismatched++; $display("FAIL b2b_adr2: got %h expected 0020", mem_adr); end
        step();
        mem_ack = 0;
        n_compared++; if ({data_wb, data_out, data_tag} !== {1'b1, 16'h0077, 2'b00}) begin n_mismatched++; $display("FAIL b2b_data2: got %b/%h/%b expected 1/0077/00", data_wb, data_out, data_tag); end
        $display("back-to-back: second data_out=%h tag=%b", data_out, data_tag);
        step();
    endtask

    task automatic test_ignore_busy();
        drive_req(1'b0, 1'b1, 1'b1, 16'h4000, 16'h0000);
        step();
        drive_req(1'b1, 1'b0, 1'b0, 16'h9999, 16'h5555);
        n_compared++; if (mem_adr !== 16'h4000) begin n_mismatched++; $display("FAIL ig_adr_a: got %h expected 4000", mem_adr); end
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'h11;
        n_compared++; if ({mem_adr, mem_we} !== {16'h4000, 1'b0}) begin n_mismatched++; $display("FAIL ig_adr_b: got %h/%b expected 4000/0", mem_adr, mem_we); end
        step();
        mem_rdata = 8'h22;
        n_compared++; if (mem_adr !== 16'h4001) begin n_mismatched++; $display("FAIL ig_adr_c: got %h expected 4001", mem_adr); end
        step();
        mem_ack = 0;
        n_compared++; if ({data_wb, data_out, data_tag} !== {1'b1, 16'h2211, 2'b01}) begin n_mismatched++; $display("FAIL ig_result: got %b/%h/%b expected 1/2211/01", data_wb, data_out, data_tag); end
        $display("ignore busy: data_out=%h tag=%b", data_out, data_tag);
        step();
    endtask

    task automatic test_reset_mid_byte1();
        int wb_seen = 0;
        drive_req(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000);
        step();
        rq_start = 0; mem_ack = 1; mem_rdata = 8'hAA;
        step();
        mem_ack = 0;
        n_compared++; if ({mem_req, mem_adr} !== {1'b1, 16'h0101}) begin n_mismatched++; $display("FAIL rm_byte1: got %b/%h expected 1/0101", mem_req, mem_adr); end
        #2 a_rst = 1'b1;
        #1;
        n_compared++; if ({mem_req, lsu_wait, data_wb} !== 3'b000) begin n_mismatched++; $display("FAIL rm_async_drop: got %b expected 000", {mem_req, lsu_wait, data_wb}); end
        step();
        if (data_wb) wb_seen++;
        a_rst = 1'b0;
        drive_req(1'b0, 1'b0, 1'b1, 16'h0555, 16'h0000);
        step();
        if (data_wb) wb_seen++;
        rq_start = 0; mem_ack = 1; mem_rdata = 8'h3C;
        n_compared++; if ({mem_req, mem_adr} !== {1'b1, 16'h0555}) begin n_mismatched++; $display("FAIL rm_accept: got %b/%h expected 1/0555", mem_req, mem_adr); end
        n_compared++; if (wb_seen !== 0) begin n_mismatched++; $display("FAIL rm_no_wb: got %0d expected 0", wb_seen); end
        step();
        mem_ack = 0;
        n_compared++; if ({data_wb, data_out} !== {1'b1, 16'h003C}) begin n_mismatched++; $display("FAIL rm_result: got %b/%h expected 1/003c", data_wb, data_out); end
        $display("reset mid-byte1: recovered data_out=%h", data_out);
        step();
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_word_load_wrap();
        test_word_store_wait();
        test_byte_store();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_byte1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
